// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit for the EXECUTE stage; owns HI/LO and
// stalls HI/LO-class instructions while a MULT/DIV is still in flight.
module ex_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ex_ctl,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [5:0] FnMfhi = 6'h10;
  localparam logic [5:0] FnMthi = 6'h11;
  localparam logic [5:0] FnMflo = 6'h12;
  localparam logic [5:0] FnMtlo = 6'h13;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;

  logic valid, hilo_op, is_muldiv, accept, start;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic unused_ctl;

  assign unused_ctl = ^{ex_ctl[3], ex_ctl[0]};

  assign valid     = (ex_ctl[2:1] == 2'b10) && !flush;
  assign hilo_op   = funct inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
  assign is_muldiv = (funct[5:2] == 4'b0110);
  assign busy      = (state_q != StIdle);
  assign stall     = busy && valid && hilo_op;
  assign accept    = valid && hilo_op && !stall;
  assign start     = accept && is_muldiv;

  // funct[0]==0 selects the signed variants (MULT, DIV)
  assign a_neg = !funct[0] && op_a[WIDTH-1];
  assign b_neg = !funct[0] && op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // Shift-add multiply: multiplier sits in the low half and shifts out as the product grows.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // Restoring divide: remainder in the high half, dividend/quotient in the low half.
  logic [WIDTH:0]     div_shift, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_rem   = div_ge ? div_shift - {1'b0, b_q} : div_shift;
  assign div_next  = {div_rem[WIDTH-1:0], prod_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   res_hi, res_lo;
  assign prod_neg = -prod_q;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (!is_div_q) begin
      res_hi = neg_res_q ? prod_neg[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
      res_lo = neg_res_q ? prod_neg[WIDTH-1:0] : prod_q[WIDTH-1:0];
    end else if (div0_q) begin
      res_hi = a_raw_q;
      res_lo = DIV0_LO[WIDTH-1:0];
    end else begin
      res_hi = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
      res_lo = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          prod_d    = {{WIDTH{1'b0}}, a_mag};
          b_d       = b_mag;
          a_raw_d   = op_a;
          cnt_d     = CntW'(WIDTH - 1);
          is_div_d  = funct[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (op_b == '0);
        end else if (accept && funct == FnMthi) begin
          hi_d = op_a;
        end else if (accept && funct == FnMtlo) begin
          lo_d = op_a;
        end
      end
      StRun: begin
        prod_d = is_div_q ? div_next : mul_next;
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StFix: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prod_q    <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  always_comb begin
    hilo_out = '0;
    if (valid && funct == FnMfhi)      hilo_out = hi_q;
    else if (valid && funct == FnMflo) hilo_out = lo_q;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus randomized MULT/DIV/MT*
// traffic checked against an arithmetic HI/LO model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ex_ctl;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, busy;
  logic [31:0] hilo_out, hi, lo;

  ex_muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ex_ctl   (ex_ctl),
    .funct    (funct),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .hilo_out (hilo_out),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    ex_ctl = {1'($urandom), 2'b10, 1'($urandom)};
    funct  = f;
    op_a   = a;
    op_b   = b;
    flush  = fl;
  endtask

  task automatic idle_in();
    ex_ctl = 4'b0000;
    funct  = 6'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    flush  = 1'b0;
  endtask

  // Architectural effect of an accepted HI/LO op.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, q, r;
    case (f)
      6'h11: m_hi = a;
      6'h13: m_lo = a;
      6'h18: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      6'h19: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      6'h1A, 6'h1B: begin
        if (b == 0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else if (f == 6'h1A) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // mode 0: idle and count busy; 1: MFLO waits on stall then MFHI; 2: independent ADD
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int mode);
    int scnt;
    int bcnt;
    scnt = 0;
    bcnt = 0;
    drive(f, a, b, 1'b0);
    #1;
    check_eq({tag, "/issue_stall"}, 32'(stall), 32'd0);
    tick();
    model(f, a, b);
    case (mode)
      1: begin
        drive(6'h12, $urandom, $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
          #1;
          if (!stall) break;
          scnt++;
          tick();
        end
        check_eq({tag, "/stall_cycles"}, 32'(scnt), 32'd33);
        check_eq({tag, "/mflo"}, hilo_out, m_lo);
        tick();
        drive(6'h10, $urandom, $urandom, 1'b0);
        #1;
        check_eq({tag, "/mfhi_stall"}, 32'(stall), 32'd0);
        check_eq({tag, "/mfhi"}, hilo_out, m_hi);
        tick();
      end
      default: begin
        if (mode == 2) drive(6'h20, $urandom, $urandom, 1'b0);
        else           idle_in();
        for (int i = 0; i < 40; i++) begin
          #1;
          if (stall) scnt++;
          if (busy) bcnt++;
          tick();
        end
        check_eq({tag, "/busy_cycles"}, 32'(bcnt), 32'd33);
        check_eq({tag, "/no_stall"}, 32'(scnt), 32'd0);
      end
    endcase
    idle_in();
    #1;
    check_eq({tag, "/hi"}, hi, m_hi);
    check_eq({tag, "/lo"}, lo, m_lo);
    check_eq({tag, "/idle"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [5:0]  f;
    rst_n = 1'b0;
    idle_in();
    tick();
    tick();
    rst_n = 1'b1;
    drive(6'h10, 32'h0, 32'h0, 1'b0);
    #1;
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/hi", hi, 32'd0);
    check_eq("rst/lo", lo, 32'd0);
    check_eq("rst/stall", 32'(stall), 32'd0);
    check_eq("rst/mfhi", hilo_out, 32'd0);
    tick();

    run_md("mult_neg", 6'h18, 32'd7, 32'hFFFF_FFFD, 0);
    check_eq("mult_neg/hi_const", hi, 32'hFFFF_FFFF);
    check_eq("mult_neg/lo_const", lo, 32'hFFFF_FFEB);
    run_md("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_md("mult_m1", 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_md("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2, 1);
    check_eq("div_neg/lo_const", lo, 32'hFFFF_FFFD);
    run_md("divu", 6'h1B, 32'hFFFF_FFF9, 32'd2, 0);
    check_eq("divu/lo_const", lo, 32'h7FFF_FFFC);
    run_md("divu_zero", 6'h1B, 32'h0000_1234, 32'd0, 1);
    check_eq("divu_zero/hi_const", hi, 32'h0000_1234);
    run_md("div_minint", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 2);
    check_eq("div_minint/lo_const", lo, 32'h8000_0000);
    run_md("div_zero_neg", 6'h1A, 32'hF000_0001, 32'd0, 0);

    // Reset mid-RUN aborts and clears HI/LO.
    drive(6'h18, 32'd1234, 32'd5678, 1'b0);
    tick();
    idle_in();
    for (int i = 0; i < 9; i++) tick();
    drive(6'h12, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    #1;
    check_eq("midrst/busy", 32'(busy), 32'd0);
    check_eq("midrst/hi", hi, 32'd0);
    check_eq("midrst/lo", lo, 32'd0);
    check_eq("midrst/stall", 32'(stall), 32'd0);
    tick();

    drive(6'h11, 32'hCAFE_F00D, $urandom, 1'b0);
    tick();
    model(6'h11, 32'hCAFE_F00D, 32'h0);
    idle_in();
    #1;
    check_eq("mthi/hi", hi, 32'hCAFE_F00D);
    drive(6'h10, 32'h0, 32'h0, 1'b1);
    #1;
    check_eq("mfhi_flushed", hilo_out, 32'd0);
    tick();

    drive(6'h18, 32'd5, 32'd6, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("flush/busy", 32'(busy), 32'd0);
      tick();
    end
    drive(6'h12, 32'h0, 32'h0, 1'b0);
    #1;
    check_eq("flush/stall", 32'(stall), 32'd0);
    check_eq("flush/lo", hilo_out, m_lo);
    tick();

    for (int n = 0; n < 20; n++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      run_md("rand_md", f, pick(), pick(), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) begin
        v = $urandom;
        f = ($urandom_range(0, 1) == 0) ? 6'h11 : 6'h13;
        drive(f, v, $urandom, 1'b0);
        tick();
        model(f, v, 32'h0);
        idle_in();
        #1;
        check_eq("rand_mt/hi", hi, m_hi);
        check_eq("rand_mt/lo", lo, m_lo);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle integer multiply/divide unit in the EXECUTE stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered EX control, the forwarded operands and the funct field (low 6 bits of the sign-extended immediate).
- Runs MULT/MULTU/DIV/DIVU iteratively in the background and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO, and raises a stall while a HI/LO-class instruction must wait for a busy operation.

Parameters:
WIDTH, 32, operand/HI/LO width; only 32 is supported.
DIV0_LO, 32'hFFFF_FFFF, value written to LO on divide-by-zero.

Ports:
clk  in  1  pipeline clock; all state changes on posedge.
rst_n  in  1  synchronous active-low reset.
ex_ctl  in  4  EX control from ID/EX; bits [2:1] = ALUOp; 2'b10 = R-type.
funct  in  6  s_extendout[5:0] from ID/EX.
op_a  in  32  forwarded rs operand.
op_b  in  32  forwarded rt operand.
flush  in  1  kills the instruction currently in EX.
stall  out  1  holds PC, IF/ID and ID/EX, and inserts a bubble into EX/MEM.
busy  out  1  an iterative operation is in progress.
hilo_out  out  32  HI (MFHI) or LO (MFLO) for the EX result mux; 0 otherwise.
hi  out  32  architectural HI.
lo  out  32  architectural LO.

Behaviour:
- Op decode is valid only when ex_ctl[2:1]==2'b10 and flush==0.
- funct codes: MFHI=0x10, MTHI=0x11, MFLO=0x12, MTLO=0x13, MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B. All are HI/LO-class. Any other funct is ignored by this block.
- stall is combinational: stall = busy & (valid HI/LO-class op in EX). No other condition asserts it.
- A stalled op is not accepted. It is re-presented every cycle because upstream is held.
- Reset (rst_n==0 at posedge): state IDLE, busy=0, hi=0, lo=0, all internal counters and accumulators 0. Reset overrides everything, including mid-operation: the op is aborted and HI/LO are cleared.
- State machine has three states: IDLE, RUN, FIX.
- IDLE -> RUN: on a non-stalled MULT/MULTU/DIV/DIVU, at accept edge N.
  - Latch the operand magnitudes (absolute values for the signed ops, raw values for the unsigned ops).
  - Latch the result-sign flags, the op type and the divide-by-zero flag (op_b==0).
  - Load iteration counter = 31.
- RUN: one iteration per cycle, 32 cycles, then go to FIX.
  - Multiply: shift-add, 64-bit product accumulator.
  - Divide: restoring, 32-bit remainder and 32-bit quotient.
- FIX: one cycle. Apply the sign correction and write HI/LO on the edge ending FIX, then go to IDLE.
  - Signed product: negated when sign(a)^sign(b).
  - Signed quotient: negated when sign(a)^sign(b).
  - Signed remainder: takes the sign of the dividend.
  - Divide-by-zero (signed or unsigned): LO=DIV0_LO, HI=op_a as latched (unmodified).
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- busy is high in RUN and FIX: 33 cycles, N+1..N+33. HI/LO hold new values from cycle N+34.
- The issuing MULT/DIV instruction itself never stalls. Independent non-HI/LO instructions proceed while busy.
- MTHI/MTLO: write op_a to HI/LO at the edge when the op is valid and not stalled.
- MFHI/MFLO: hilo_out = current hi/lo combinationally. This value is used only when stall==0.
- A flush in the accept cycle means the op is not started. flush has no effect once the unit is in RUN or FIX.
- MIN_INT / -1 (signed) gives LO=0x80000000, HI=0; it falls out of the magnitude arithmetic and needs no special case.

Test Plan:
1. MULT, a=7, b=0xFFFFFFFD (-3); then idle 40 cycles -> busy high exactly 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
2. MULTU, a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; same op as MULT -> HI=0, LO=1.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with same operands -> LO=0x7FFFFFFC, HI=1.
4. DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. MULT accepted at N, MFLO at N+1 -> stall high N+1..N+33 (33 cycles), low at N+34 with hilo_out=new LO. Independent ADD at N+1 instead -> stall stays 0.
6. rst_n=0 at cycle 10 of RUN -> next cycle busy=0, hi=lo=0, stall=0. MTHI 0xCAFEF00D while idle -> hi=0xCAFEF00D next cycle. MULT with flush=1 -> busy never rises.
